// File: rtl/simd_bus_pkg.sv
// Shared types for the SIMD host-bus master: command opcodes, FSM states
// and bus phase selectors.
// No ports; imported by simd_bus_master and simd_phase_timer.
package simd_bus_pkg;

  typedef enum logic [1:0] {
    OP_WRITE      = 2'd0,
    OP_EXEC       = 2'd1,
    OP_READ       = 2'd2,
    OP_READ_BURST = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RSP_WAIT
  } state_t;

  typedef enum logic [1:0] {
    ADDR,
    DATA,
    EXEC,
    READ
  } phase_t;

endpackage

// File: rtl/simd_phase_timer.sv
// Down-counter timing the SETUP/STROBE/HOLD sub-phases of a bus phase.
// Latency: loaded with (duration-1) on the edge entering a timed state; done is high in the last cycle of it.
// Ports: clk, rst (sync, active-high), load, sel (state being entered), done.
module simd_phase_timer
  import simd_bus_pkg::*;
#(
  parameter int T_SU = 1,
  parameter int T_PW = 2,
  parameter int T_H  = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  state_t sel,
  output logic   done
);

  localparam int T_MAX = (T_SU > T_PW) ? ((T_SU > T_H) ? T_SU : T_H)
                                       : ((T_PW > T_H) ? T_PW : T_H);
  localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      case (sel)
        SETUP:   cnt <= CW'(T_SU - 1);
        STROBE:  cnt <= CW'(T_PW - 1);
        HOLD:    cnt <= CW'(T_H - 1);
        default: cnt <= '0;
      endcase
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Zero means the current sub-phase is in its final cycle.
  assign done = (cnt == '0);

endmodule

// File: rtl/simd_bus_master.sv
// Issues byte commands as timed CS/WR/RD/AD/excute phases on the SIMD host bus.
// Latency: each phase takes T_SU+T_PW+T_H cycles; WRITE is two phases, reads add >=1 response cycle per byte.
// Ports: cmd_* (valid/ready in), rsp_* (valid/ready out; stalls the burst in RSP_WAIT), bus pins CS/WR/RD/AD/excute/bus_*.
module simd_bus_master
  import simd_bus_pkg::*;
#(
  parameter int bw       = 8,
  parameter int reg_size = 32,
  parameter int T_SU     = 1,
  parameter int T_PW     = 2,
  parameter int T_H      = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [bw-1:0] cmd_addr,
  input  logic [bw-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [bw-1:0] rsp_data,
  output logic          rsp_last,
  output logic          CS,
  output logic          WR,
  output logic          RD,
  output logic          AD,
  output logic          excute,
  output logic [bw-1:0] bus_dout,
  output logic          bus_oe,
  input  logic [bw-1:0] bus_din
);

  localparam int CW = (reg_size > 1) ? $clog2(reg_size) : 1;

  state_t        state, state_nxt;
  phase_t        phase, phase_nxt;
  op_t           op_q;
  logic [bw-1:0] data_q;
  logic [CW-1:0] byte_cnt;
  logic          t_done;
  logic          last_byte;
  logic          accept;
  logic          enter_setup;

  assign accept      = cmd_valid & cmd_ready;
  assign last_byte   = (op_q != OP_READ_BURST) || (byte_cnt == CW'(reg_size - 1));
  // SETUP is never re-entered from itself, so any entry is a fresh phase.
  assign enter_setup = (state_nxt == SETUP) && (state != SETUP);

  simd_phase_timer #(
    .T_SU (T_SU),
    .T_PW (T_PW),
    .T_H  (T_H)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state_nxt != state),
    .sel  (state_nxt),
    .done (t_done)
  );

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = SETUP;
          case (op_t'(cmd_op))
            OP_WRITE: phase_nxt = ADDR;
            OP_EXEC:  phase_nxt = EXEC;
            default:  phase_nxt = READ;
          endcase
        end
      end
      SETUP:  if (t_done) state_nxt = STROBE;
      STROBE: if (t_done) state_nxt = HOLD;
      HOLD: begin
        if (t_done) begin
          if (phase == ADDR) begin
            state_nxt = SETUP;
            phase_nxt = DATA;
          end else if (phase == READ) begin
            state_nxt = RSP_WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      RSP_WAIT: if (rsp_ready) state_nxt = last_byte ? IDLE : SETUP;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= ADDR;
      op_q     <= OP_WRITE;
      data_q   <= '0;
      byte_cnt <= '0;
      bus_dout <= '0;
      AD       <= 1'b0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      if (accept) begin
        op_q     <= op_t'(cmd_op);
        data_q   <= cmd_data;
        byte_cnt <= '0;
      end else if (rsp_valid && rsp_ready) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
      // Bus byte and AD only move when a phase starts, so they are
      // stable through STROBE and HOLD. The address goes straight from
      // the command port since ADDR is only ever entered from IDLE.
      if (enter_setup) begin
        AD <= (phase_nxt == ADDR);
        case (phase_nxt)
          ADDR:    bus_dout <= cmd_addr;
          DATA:    bus_dout <= data_q;
          default: bus_dout <= '0;
        endcase
      end
      // Sample the peripheral on the edge that ends the last RD-high cycle.
      if (state == STROBE && t_done && phase == READ) begin
        rsp_data <= bus_din;
      end
    end
  end

  assign cmd_ready = (state == IDLE) & ~rst;
  assign CS        = (state != IDLE);
  assign WR        = (state == STROBE) && (phase == ADDR || phase == DATA);
  assign RD        = (state == STROBE) && (phase == READ);
  assign excute    = (state == STROBE) && (phase == EXEC);
  assign bus_oe    = (state == SETUP || state == STROBE || state == HOLD) &&
                     (phase == ADDR || phase == DATA);
  assign rsp_valid = (state == RSP_WAIT);
  assign rsp_last  = rsp_valid & last_byte;

endmodule

// File: tb/tb_simd_bus_master.sv
// Self-checking bench for simd_bus_master: default-timing instance plus a
// second instance with stretched T_SU/T_PW/T_H.
// Expected waveforms are derived from phase arithmetic and a byte-source table.
module tb_simd_bus_master;

  localparam int RS  = 32;
  localparam int SU  = 1, PW = 2, HD = 1, L = SU + PW + HD;
  localparam int SU2 = 2, PW2 = 3, HD2 = 2, L2 = SU2 + PW2 + HD2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default-timing instance
  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_last;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr, cmd_data, rsp_data, bus_dout, bus_din;
  logic       cs, wr, rd, ad, ex, oe;

  simd_bus_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .CS(cs), .WR(wr), .RD(rd), .AD(ad), .excute(ex),
    .bus_dout(bus_dout), .bus_oe(oe), .bus_din(bus_din)
  );

  // stretched-timing instance
  logic       cmd_valid2, cmd_ready2, rsp_valid2, rsp_last2;
  logic [7:0] rsp_data2, bus_dout2;
  logic       cs2, wr2, rd2, ad2, ex2, oe2;

  simd_bus_master #(.T_SU(SU2), .T_PW(PW2), .T_H(HD2)) dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_op(2'd1),
    .cmd_addr(8'h00), .cmd_data(8'h00),
    .rsp_valid(rsp_valid2), .rsp_ready(1'b1), .rsp_data(rsp_data2), .rsp_last(rsp_last2),
    .CS(cs2), .WR(wr2), .RD(rd2), .AD(ad2), .excute(ex2),
    .bus_dout(bus_dout2), .bus_oe(oe2), .bus_din(8'h00)
  );

  int tests = 0;
  int fails = 0;

  // Peripheral model: the n-th RD pulse of a command returns src[n].
  logic [7:0] src [0:RS-1];
  int   rd_rises = 0, rd_falls = 0, wr_rises = 0, rd_base = 0;
  logic rd_q = 1'b0, wr_q = 1'b0;

  assign bus_din = src[5'(rd_falls - rd_base)];

  always @(negedge clk) begin
    if (rd && !rd_q) rd_rises <= rd_rises + 1;
    if (!rd && rd_q) rd_falls <= rd_falls + 1;
    if (wr && !wr_q) wr_rises <= wr_rises + 1;
    rd_q <= rd;
    wr_q <= wr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one command on the default instance and checks every cycle from
  // accept to the return of cmd_ready. Each READ byte is held in RSP_WAIT
  // for a random stall in [stall_lo, stall_hi] before rsp_ready rises.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                         input int stall_lo, input int stall_hi, input string tag);
    int         nph, stall;
    bit         is_rd, strobe;
    logic [7:0] exp_v;
    nph   = (op == 2'd0) ? 2 : (op == 2'd3) ? RS : 1;
    is_rd = op[1];
    rd_base = rd_falls;
    chk({tag, "/ready_at_start"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int p = 0; p < nph; p++) begin
      for (int pos = 0; pos < L; pos++) begin
        strobe = (pos >= SU) && (pos < SU + PW);
        // {CS, WR, RD, excute, bus_oe, cmd_ready, rsp_valid, rsp_last}
        exp_v = {1'b1, strobe && op == 2'd0, strobe && is_rd, strobe && op == 2'd1,
                 op == 2'd0, 1'b0, 1'b0, 1'b0};
        chk($sformatf("%s/ctrl p%0d c%0d", tag, p, pos),
            {cs, wr, rd, ex, oe, cmd_ready, rsp_valid, rsp_last}, exp_v);
        if (op == 2'd0) begin
          chk($sformatf("%s/ad p%0d c%0d", tag, p, pos), ad, (p == 0));
          chk($sformatf("%s/dout p%0d c%0d", tag, p, pos), bus_dout, (p == 0) ? a : d);
        end
        if (op == 2'd1) chk($sformatf("%s/ad c%0d", tag, pos), ad, 0);
        @(negedge clk);
      end
      if (is_rd) begin
        stall = $urandom_range(stall_hi, stall_lo);
        for (int w = 0; w <= stall; w++) begin
          exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (op == 2'd2) || (p == nph - 1)};
          chk($sformatf("%s/rsp_ctrl b%0d w%0d", tag, p, w),
              {cs, wr, rd, ex, oe, cmd_ready, rsp_valid, rsp_last}, exp_v);
          chk($sformatf("%s/rsp_data b%0d w%0d", tag, p, w), rsp_data, src[p]);
          rsp_ready = (w == stall);
          @(negedge clk);
        end
        rsp_ready = 1'b0;
      end
    end
    chk({tag, "/idle_after"}, {cs, wr, rd, ex, oe, cmd_ready, rsp_valid, rsp_last}, 8'b0000_0100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, w0, ex_cnt;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b0; cmd_valid2 = 1'b0;
    for (int i = 0; i < RS; i++) src[i] = 8'(i);
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset/ctrl", {cs, wr, rd, ex, ad, oe, cmd_ready, rsp_valid, rsp_last}, 9'b0);
    chk("reset/bus_dout", bus_dout, 0);
    chk("reset/rsp_data", rsp_data, 0);
    chk("reset/dut2_ready", cmd_ready2, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset/ready", cmd_ready, 1);

    // Directed scenarios
    run_cmd(2'd0, 8'h05, 8'hA7, 0, 0, "write_05_a7");
    r0 = rd_rises;
    run_cmd(2'd1, 8'h00, 8'h00, 0, 0, "exec");
    chk("exec/no_rd", rd_rises - r0, 0);
    src[0] = 8'h3C;
    run_cmd(2'd2, 8'h00, 8'h00, 5, 5, "read_stall5");
    for (int i = 0; i < RS; i++) src[i] = 8'(i);
    r0 = rd_rises;
    run_cmd(2'd3, 8'h00, 8'h00, 0, 0, "burst_inc");
    @(negedge clk);
    chk("burst_inc/rd_pulses", rd_rises - r0, RS);

    // Randomized commands
    repeat (4) run_cmd(2'd0, 8'($urandom_range(64, 0)), 8'($urandom), 0, 0, "rand_write");
    repeat (3) begin
      src[0] = 8'($urandom);
      run_cmd(2'd2, 8'h00, 8'h00, 0, 4, "rand_read");
    end
    for (int i = 0; i < RS; i++) src[i] = 8'($urandom);
    r0 = rd_rises;
    run_cmd(2'd3, 8'h00, 8'h00, 0, 2, "rand_burst");
    @(negedge clk);
    chk("rand_burst/rd_pulses", rd_rises - r0, RS);

    // Reset in the first STROBE cycle of the data phase of a WRITE
    w0 = wr_rises;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 8'h11; cmd_data = 8'h22;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid/wr_before", {wr, ad, bus_dout}, {1'b1, 1'b0, 8'h22});
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid/drop", {cs, wr, rd, ex, cmd_ready}, 5'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid/ready_after", cmd_ready, 1);
    repeat (3) @(negedge clk);
    chk("rst_mid/wr_edges", wr_rises - w0, 2);
    chk("rst_mid/cs_idle", cs, 0);
    run_cmd(2'd2, 8'h00, 8'h00, 0, 1, "read_after_rst");

    // Stretched timing: EXEC strobe T_PW wide, CS for T_SU+T_PW+T_H cycles
    chk("dut2/ready", cmd_ready2, 1);
    cmd_valid2 = 1'b1;
    @(negedge clk);
    cmd_valid2 = 1'b0;
    ex_cnt = 0;
    for (int c = 0; c < L2; c++) begin
      chk($sformatf("dut2/cs c%0d", c), cs2, 1);
      chk($sformatf("dut2/ex c%0d", c), {ex2, wr2, rd2}, {(c >= SU2) && (c < SU2 + PW2), 2'b00});
      if (ex2) ex_cnt++;
      @(negedge clk);
    end
    chk("dut2/ex_width", ex_cnt, PW2);
    chk("dut2/idle_after", {cs2, cmd_ready2}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
